// File: rtl/issue_pkg.sv
// ============================================================================
// Module : issue_pkg
// Brief  : Shared types and constants for the dual-issue scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_pkg;

  typedef enum logic [0:0] {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 32;

endpackage

`default_nettype wire

// File: rtl/src_match.sv
// ============================================================================
// Module : src_match
// Brief  : Flags a destination register that feeds either of two sources.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module src_match
  import issue_pkg::*;
(
  input  logic       en_i,
  input  logic [4:0] dst_i,
  input  logic [4:0] src1_i,
  input  logic [4:0] src2_i,
  output logic       match_o
);

  // Register zero is hard-wired, so it never carries a dependency.
  assign match_o = en_i && (dst_i != REG_ZERO) &&
                   ((dst_i == src1_i) || (dst_i == src2_i));

endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
// ============================================================================
// Module : issue_scheduler
// Brief  : Dual-issue pair/split scheduler with load-use stall, branch flush
//          and pair/stall performance counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_scheduler
  import issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidDA,
  input  logic             ValidDB,
  input  logic [4:0]       Src1DA,
  input  logic [4:0]       Src2DA,
  input  logic [4:0]       Src1DB,
  input  logic [4:0]       Src2DB,
  input  logic [4:0]       DstDA,
  input  logic [4:0]       DstDB,
  input  logic             RegWriteDA,
  input  logic             RegWriteDB,
  input  logic             MemtoRegDA,
  input  logic             MemtoRegDB,
  input  logic             MemWriteDA,
  input  logic             MemWriteDB,
  input  logic [4:0]       DstEA,
  input  logic [4:0]       DstEB,
  input  logic             MemtoRegEA,
  input  logic             MemtoRegEB,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushEA,
  output logic             FlushEB,
  output logic             SelBtoA,
  output logic [CNT_W-1:0] PairCount,
  output logic [CNT_W-1:0] StallCount
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic raw_ab, lu_ea_a, lu_eb_a, lu_ea_b, lu_eb_b;
  logic conflict, lu_a, lu_b, lu_stall;
  logic mem_a, mem_b;
  logic unused_in;

  // Slot B's own destination only matters to later stages, not to issue.
  assign unused_in = ^{RegWriteDB, DstDB};

  src_match u_raw_ab (
    .en_i    (ValidDA && ValidDB && RegWriteDA),
    .dst_i   (DstDA),
    .src1_i  (Src1DB),
    .src2_i  (Src2DB),
    .match_o (raw_ab)
  );

  src_match u_lu_ea_a (
    .en_i    (ValidDA && MemtoRegEA),
    .dst_i   (DstEA),
    .src1_i  (Src1DA),
    .src2_i  (Src2DA),
    .match_o (lu_ea_a)
  );

  src_match u_lu_eb_a (
    .en_i    (ValidDA && MemtoRegEB),
    .dst_i   (DstEB),
    .src1_i  (Src1DA),
    .src2_i  (Src2DA),
    .match_o (lu_eb_a)
  );

  src_match u_lu_ea_b (
    .en_i    (ValidDB && MemtoRegEA),
    .dst_i   (DstEA),
    .src1_i  (Src1DB),
    .src2_i  (Src2DB),
    .match_o (lu_ea_b)
  );

  src_match u_lu_eb_b (
    .en_i    (ValidDB && MemtoRegEB),
    .dst_i   (DstEB),
    .src1_i  (Src1DB),
    .src2_i  (Src2DB),
    .match_o (lu_eb_b)
  );

  assign mem_a    = MemtoRegDA || MemWriteDA;
  assign mem_b    = MemtoRegDB || MemWriteDB;
  assign conflict = raw_ab || (ValidDA && ValidDB && mem_a && mem_b);
  assign lu_a     = lu_ea_a || lu_eb_a;
  assign lu_b     = lu_ea_b || lu_eb_b;

  always_comb begin
    state_d  = state_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushEA  = 1'b1;
    FlushEB  = 1'b1;
    SelBtoA  = 1'b0;
    lu_stall = 1'b0;
    if (reset) begin
      state_d = PAIR;
    end else if (BranchTakenE) begin
      FlushD  = 1'b1;
      state_d = PAIR;
    end else if (state_q == PAIR) begin
      // A slot-B load-use under a conflict is deferred to the SPLIT cycle.
      if (lu_a || (lu_b && !conflict)) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        lu_stall = 1'b1;
      end else if (conflict) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        FlushEA = 1'b0;
        state_d = SPLIT;
      end else begin
        FlushEA = !ValidDA;
        FlushEB = !ValidDB;
      end
    end else begin
      if (lu_b) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        lu_stall = 1'b1;
      end else begin
        SelBtoA = 1'b1;
        FlushEA = 1'b0;
        state_d = PAIR;
      end
    end
  end

  always_comb begin
    pair_cnt_d  = pair_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!FlushEA && !FlushEB) pair_cnt_d = pair_cnt_q + 1'b1;
    if (lu_stall)             stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PAIR;
      pair_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PairCount  = pair_cnt_q;
  assign StallCount = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
// ============================================================================
// Module : tb_issue_scheduler
// Brief  : Vector table plus multi-cycle sequences for issue_scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidDA, ValidDB;
  logic [4:0]  Src1DA, Src2DA, Src1DB, Src2DB, DstDA, DstDB;
  logic        RegWriteDA, RegWriteDB, MemtoRegDA, MemtoRegDB, MemWriteDA, MemWriteDB;
  logic [4:0]  DstEA, DstEB;
  logic        MemtoRegEA, MemtoRegEB, BranchTakenE;
  logic        StallF, StallD, FlushD, FlushEA, FlushEB, SelBtoA;
  logic [31:0] PairCount, StallCount;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .reset(reset),
    .ValidDA(ValidDA), .ValidDB(ValidDB),
    .Src1DA(Src1DA), .Src2DA(Src2DA), .Src1DB(Src1DB), .Src2DB(Src2DB),
    .DstDA(DstDA), .DstDB(DstDB),
    .RegWriteDA(RegWriteDA), .RegWriteDB(RegWriteDB),
    .MemtoRegDA(MemtoRegDA), .MemtoRegDB(MemtoRegDB),
    .MemWriteDA(MemWriteDA), .MemWriteDB(MemWriteDB),
    .DstEA(DstEA), .DstEB(DstEB),
    .MemtoRegEA(MemtoRegEA), .MemtoRegEB(MemtoRegEB),
    .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushEA(FlushEA), .FlushEB(FlushEB), .SelBtoA(SelBtoA),
    .PairCount(PairCount), .StallCount(StallCount)
  );

  // Output word order: {StallF, StallD, FlushD, FlushEA, FlushEB, SelBtoA}
  localparam logic [5:0] O_IDLE   = 6'b000110;
  localparam logic [5:0] O_ISSUE  = 6'b000000;
  localparam logic [5:0] O_AONLY  = 6'b000010;
  localparam logic [5:0] O_SPLIT1 = 6'b110010;
  localparam logic [5:0] O_SPLIT2 = 6'b000011;
  localparam logic [5:0] O_LU     = 6'b110110;
  localparam logic [5:0] O_BR     = 6'b001110;

  typedef struct packed {
    logic       va, vb;
    logic [4:0] s1a, s2a, s1b, s2b, da, db;
    logic       rwa, mra, mwa, mrb, mwb;
    logic [4:0] dea, deb;
    logic       mea, meb, br;
    logic [5:0] exp;
  } t_vec;

  int          checks = 0;
  int          failures = 0;
  logic [5:0]  exp_q[$];
  t_vec        tbl[14];
  t_vec        v;

  function automatic t_vec base();
    t_vec b;
    b = '0;
    b.va = 1'b1; b.vb = 1'b1; b.rwa = 1'b1;
    b.s1a = 5'd1; b.s2a = 5'd2; b.da = 5'd3;
    b.s1b = 5'd4; b.s2b = 5'd6; b.db = 5'd7;
    b.exp = O_ISSUE;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input t_vec x);
    ValidDA = x.va;   ValidDB = x.vb;
    Src1DA = x.s1a;   Src2DA = x.s2a;  Src1DB = x.s1b;  Src2DB = x.s2b;
    DstDA = x.da;     DstDB = x.db;
    RegWriteDA = x.rwa; RegWriteDB = x.vb;
    MemtoRegDA = x.mra; MemWriteDA = x.mwa;
    MemtoRegDB = x.mrb; MemWriteDB = x.mwb;
    DstEA = x.dea;    DstEB = x.deb;
    MemtoRegEA = x.mea; MemtoRegEB = x.meb;
    BranchTakenE = x.br;
  endtask

  // Called at a negedge: drive, score the combinational outputs, cross one posedge.
  task automatic step(input t_vec x, input string name);
    logic [5:0] e;
    apply(x);
    exp_q.push_back(x.exp);
    #1;
    e = exp_q.pop_front();
    chk(name, {26'd0, StallF, StallD, FlushD, FlushEA, FlushEB, SelBtoA}, {26'd0, e});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    apply('0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {26'd0, StallF, StallD, FlushD, FlushEA, FlushEB, SelBtoA}, {26'd0, O_IDLE});
    chk("reset_pair", PairCount, 32'd0);
    chk("reset_stall", StallCount, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) tbl[i] = base();
    tbl[0].va = 1'b0; tbl[0].vb = 1'b0; tbl[0].exp = O_IDLE;
    tbl[2].vb = 1'b0; tbl[2].exp = O_AONLY;
    tbl[3].s1b = 5'd3; tbl[3].exp = O_SPLIT1;
    tbl[4].da = 5'd0; tbl[4].s1b = 5'd0;
    tbl[5].s2b = 5'd3; tbl[5].rwa = 1'b0;
    tbl[6].mwa = 1'b1; tbl[6].mwb = 1'b1; tbl[6].exp = O_SPLIT1;
    tbl[7].mra = 1'b1; tbl[7].mwb = 1'b1; tbl[7].vb = 1'b0; tbl[7].exp = O_AONLY;
    tbl[8].meb = 1'b1; tbl[8].deb = 5'd2; tbl[8].exp = O_LU;
    tbl[9].mea = 1'b1; tbl[9].dea = 5'd6; tbl[9].exp = O_LU;
    tbl[10].mea = 1'b1; tbl[10].dea = 5'd0; tbl[10].s1a = 5'd0;
    tbl[11].meb = 1'b1; tbl[11].deb = 5'd1; tbl[11].br = 1'b1; tbl[11].exp = O_BR;
    tbl[12].dea = 5'd1;
    tbl[13].s2b = 5'd3; tbl[13].mea = 1'b1; tbl[13].dea = 5'd4; tbl[13].exp = O_SPLIT1;

    for (int i = 0; i < 14; i++) begin
      do_reset();
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // RAW split: A then B via SelBtoA; no pair issue counted.
    do_reset();
    v = base(); v.s1b = 5'd3; v.exp = O_SPLIT1;
    step(v, "raw_c1");
    v.exp = O_SPLIT2;
    step(v, "raw_c2");
    chk("raw_paircnt", PairCount, 32'd0);
    v = base();
    step(v, "raw_back_pair");
    chk("raw_pair_after", PairCount, 32'd1);

    // Load-use on slot A from lane B.
    do_reset();
    v = base(); v.s2a = 5'd5; v.meb = 1'b1; v.deb = 5'd5; v.exp = O_LU;
    step(v, "lu_stall");
    chk("lu_stallcnt", StallCount, 32'd1);
    v.meb = 1'b0; v.exp = O_ISSUE;
    step(v, "lu_issue");
    chk("lu_paircnt", PairCount, 32'd1);

    // Branch while in SPLIT returns to PAIR.
    do_reset();
    v = base(); v.s1b = 5'd3; v.exp = O_SPLIT1;
    step(v, "br_enter_split");
    v.br = 1'b1; v.exp = O_BR;
    step(v, "br_in_split");
    v.br = 1'b0; v.exp = O_SPLIT1;
    step(v, "br_state_pair");

    // Both memory ops split over two cycles.
    do_reset();
    v = base(); v.mwa = 1'b1; v.mwb = 1'b1; v.exp = O_SPLIT1;
    step(v, "mem_c1");
    v.exp = O_SPLIT2;
    step(v, "mem_c2");

    // Slot-B load-use in SPLIT stalls, counted only there.
    do_reset();
    v = base(); v.s1b = 5'd3; v.mea = 1'b1; v.dea = 5'd6; v.exp = O_SPLIT1;
    step(v, "slu_c1");
    v.exp = O_LU;
    step(v, "slu_c2");
    chk("slu_stallcnt", StallCount, 32'd1);
    v.mea = 1'b0; v.exp = O_SPLIT2;
    step(v, "slu_c3");

    // Counter wrap, then reset asserted while in SPLIT.
    do_reset();
    force dut.pair_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pair_cnt_q;
    chk("wrap_preload", PairCount, 32'hFFFF_FFFF);
    v = base();
    step(v, "wrap_issue");
    chk("wrap_pair0", PairCount, 32'd0);
    v = base(); v.meb = 1'b1; v.deb = 5'd1; v.exp = O_LU;
    step(v, "pre_rst_lu");
    v = base(); v.s1b = 5'd3; v.exp = O_SPLIT1;
    step(v, "pre_rst_split");
    chk("pre_rst_counts", {PairCount[15:0], StallCount[15:0]}, {16'd0, 16'd1});
    v.br = 1'b1;
    apply(v);
    reset = 1'b1;
    #1;
    chk("rst_split_outs", {26'd0, StallF, StallD, FlushD, FlushEA, FlushEB, SelBtoA}, {26'd0, O_IDLE});
    chk("rst_split_stall", StallCount, 32'd0);
    chk("rst_split_pair", PairCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v.br = 1'b0; v.exp = O_SPLIT1;
    step(v, "post_rst_pair");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have one clock and one reset, reset asynchronous and active-high; ports:
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 ValidDA, ValidDB  in  1 each  decode slot A/B holds a real instruction.
REQ-005 Src1DA, Src2DA, Src1DB, Src2DB  in  5 each  source register numbers (0 = unused).
REQ-006 DstDA, DstDB  in  5 each  destination register numbers.
REQ-007 RegWriteDA, RegWriteDB, MemtoRegDA, MemtoRegDB, MemWriteDA, MemWriteDB  in  1 each  decode control bits.
REQ-008 DstEA, DstEB  in  5 each; MemtoRegEA, MemtoRegEB  in  1 each  execute-stage lane destination and load flag.
REQ-009 BranchTakenE  in  1  taken branch/jump resolved in execute.
REQ-010 StallF, StallD  out  1 each  hold fetch PC / decode register.
REQ-011 FlushD  out  1  bubble decode register.
REQ-012 FlushEA, FlushEB  out  1 each  bubble execute lane A/B register.
REQ-013 SelBtoA  out  1  execute lane A loads decode slot B fields.
REQ-014 PairCount, StallCount  out  32 each  performance counters.

Function
REQ-015 FSM states: PAIR (normal), SPLIT (slot A issued, slot B pending); all outputs combinational from state and inputs except counters.
REQ-016 Intra-pair conflict: ValidDA, ValidDB, and either (RegWriteDA, DstDA!=0, DstDA equals Src1DB or Src2DB) or (slot A memory op and slot B memory op).
REQ-017 Load-use hazard for an instruction: some E lane has MemtoRegE=1, DstE!=0, DstE equals its Src1 or Src2.
REQ-018 Priority: BranchTakenE > load-use hazard > conflict > normal issue.
REQ-019 BranchTakenE=1 (any state): FlushD=1, FlushEA=FlushEB=1, StallF=StallD=0, SelBtoA=0, next PAIR.
REQ-020 PAIR, load-use on slot A, or on slot B when no conflict: StallF=StallD=1, FlushEA=FlushEB=1, stay PAIR.
REQ-021 PAIR, conflict: issue A only — FlushEA=0, FlushEB=1, StallF=StallD=1, next SPLIT.
REQ-022 PAIR, no hazard/conflict: FlushEA=!ValidDA, FlushEB=!ValidDB, StallF=StallD=0.
REQ-023 SPLIT, load-use on slot B: StallF=StallD=1, FlushEA=FlushEB=1, stay SPLIT.
REQ-024 SPLIT, otherwise: SelBtoA=1, FlushEA=0, FlushEB=1, StallF=StallD=0, next PAIR.
REQ-025 Slot-A hazard checks ignore slot B when ValidDB=0; no SPLIT entry when ValidDB=0.
REQ-026 PairCount +1 on each cycle with FlushEA=FlushEB=0; StallCount +1 on each load-use stall cycle; both wrap modulo 2^32.
REQ-027 SelBtoA=0 in every case other than REQ-024.

Reset
REQ-028 reset asserted (any time, including in SPLIT): state PAIR, PairCount=StallCount=0 immediately.
REQ-029 During reset: StallF=StallD=0, FlushD=0, FlushEA=FlushEB=1, SelBtoA=0.
REQ-030 First rising edge after deassertion evaluates from PAIR.

Structure
REQ-031 Shared package issue_pkg SHALL hold the state enum (PAIR, SPLIT), REG_ZERO=5'd0, counter width 32.
REQ-032 One sub-module src_match (5-bit dst vs two sources, zero-excluded, enable) SHALL be instantiated for every comparison.

Verification
REQ-033 A: DstDA=3 RegWrite; B: Src1DB=3 -> cycle1 FlushEA=0 FlushEB=1 StallD=1; cycle2 SelBtoA=1 StallD=0; PairCount unchanged.
REQ-034 E lane B load DstEB=5; D slot A Src2DA=5 -> one stall cycle, FlushEA=FlushEB=1, StallCount=1, then pair issue.
REQ-035 State SPLIT with BranchTakenE=1 -> FlushD=1, FlushEA=FlushEB=1, next cycle state PAIR.
REQ-036 Both slots MemWrite, independent regs -> split issue over two cycles; DstDA=0 with matching Src1DB=0 -> no split.
REQ-037 Preload PairCount=32'hFFFFFFFF, one pair issue -> 0; assert reset in SPLIT -> counters 0, outputs per REQ-029.
